// File: rtl/uart_rx_fifo.sv
// Receive UART with runtime frame format, per-frame error flags and a valid/ready output FIFO.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit as a 3-sample majority around mid-bit.
module uart_rx_fifo #(
   parameter int DATA_MAX     = 9,
   parameter int SAMPLE_WIDTH = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [3:0]              data_width,
   input  logic [1:0]              parity,
   input  logic                    stop_bits,
   input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
   input  logic                    rx_in,
   output logic [DATA_MAX-1:0]     data_o,
   output logic                    parity_err_o,
   output logic                    frame_err_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    overflow_o,
   input  logic                    overflow_clr,
   output logic [2:0]              state_o,
   output logic                    busy_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int W  = DATA_MAX + 2;

   typedef enum logic [1:0] {
      NO_PARITY   = 2'd0,
      ODD_PARITY  = 2'd1,
      EVEN_PARITY = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic                    rx_meta_q, rx_s_q;
   logic [SAMPLE_WIDTH-1:0] cnt_q, cnt_d, spb_q;
   logic [3:0]              dw_q, dw_clamp;
   parity_t                 par_q;
   logic                    stop2_q;
   logic [3:0]              idx_q, idx_d;
   logic [DATA_MAX-1:0]     shift_q, shift_d;
   logic                    perr_q, perr_d, ferr_q, ferr_d;
   logic                    stop_idx_q, stop_idx_d;
   logic                    armed_q, armed_d;
   logic                    start_load, raw_strobe, strobe, bit_val;
   logic                    push;
   logic [W-1:0]            push_word;

   logic [W-1:0]            mem_q [FIFO_DEPTH];
   logic [AW:0]             wr_ptr_q, rd_ptr_q;
   logic                    full, empty, pop, do_push, ovf_set, ovf_q;

   assign raw_strobe = (state_q != S_IDLE) && (cnt_q == '0);

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic strobe_q, rx_d1_q, rx_d2_q;

   // Strobe is delayed one clock so the sample after the nominal mid-bit is available.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         strobe_q <= 1'b0;
         rx_d1_q  <= 1'b1;
         rx_d2_q  <= 1'b1;
      end else begin
         strobe_q <= raw_strobe;
         rx_d1_q  <= rx_s_q;
         rx_d2_q  <= rx_d1_q;
      end
   end

   assign strobe  = strobe_q;
   assign bit_val = (rx_d2_q & rx_d1_q) | (rx_d2_q & rx_s_q) | (rx_d1_q & rx_s_q);
`else
   assign strobe  = raw_strobe;
   assign bit_val = rx_s_q;
`endif

   always_comb begin
      dw_clamp = data_width;
      if (data_width < 4'd5)
         dw_clamp = 4'd5;
      else if (data_width > 4'(DATA_MAX))
         dw_clamp = 4'(DATA_MAX);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (start_load)
         cnt_d = samples_per_bit >> 1;
      else if (state_q != S_IDLE)
         cnt_d = (cnt_q == '0) ? spb_q - SAMPLE_WIDTH'(1) : cnt_q - SAMPLE_WIDTH'(1);
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      stop_idx_d = stop_idx_q;
      armed_d    = armed_q;
      start_load = 1'b0;
      push       = 1'b0;
      push_word  = '0;
      case (state_q)
         S_IDLE: begin
            // After a frame ending on a low stop bit, wait for the line to go high before re-arming.
            if (rx_s_q)
               armed_d = 1'b1;
            if (enable && armed_q && !rx_s_q) begin
               state_d    = S_START;
               start_load = 1'b1;
               perr_d     = 1'b0;
               ferr_d     = 1'b0;
            end
         end
         S_START: begin
            if (strobe) begin
               if (bit_val) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  idx_d   = '0;
                  shift_d = '0;
               end
            end
         end
         S_DATA: begin
            if (strobe) begin
               shift_d[idx_q] = bit_val;
               idx_d          = idx_q + 4'd1;
               if (idx_q == dw_q - 4'd1) begin
                  state_d    = (par_q != NO_PARITY) ? S_PARITY : S_STOP;
                  stop_idx_d = 1'b0;
               end
            end
         end
         S_PARITY: begin
            if (strobe) begin
               if (par_q == ODD_PARITY)
                  perr_d = ~(^shift_q ^ bit_val);
               else
                  perr_d = ^shift_q ^ bit_val;
               state_d    = S_STOP;
               stop_idx_d = 1'b0;
            end
         end
         S_STOP: begin
            if (strobe) begin
               ferr_d = ferr_q | ~bit_val;
               if (stop_idx_q == stop2_q) begin
                  push      = 1'b1;
                  push_word = {perr_q, ferr_q | ~bit_val, shift_q};
                  state_d   = S_IDLE;
                  armed_d   = bit_val;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (!enable && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         push    = 1'b0;
      end
   end

   // Output handshake: the head entry transfers on any clock where valid_o and ready_i are both high;
   // valid_o never drops without a transfer and data_o/flags stay stable while valid_o is held.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop     = !empty && ready_i;
   assign do_push = push && (!full || pop);
   assign ovf_set = push && full && !pop;

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q[AW-1:0]] <= push_word;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         spb_q      <= '0;
         dw_q       <= 4'd5;
         par_q      <= NO_PARITY;
         stop2_q    <= 1'b0;
         idx_q      <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         stop_idx_q <= 1'b0;
         armed_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ovf_q      <= 1'b0;
      end else begin
         rx_meta_q  <= rx_in;
         rx_s_q     <= rx_meta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         stop_idx_q <= stop_idx_d;
         armed_q    <= armed_d;
         if (start_load) begin
            spb_q   <= samples_per_bit;
            dw_q    <= dw_clamp;
            par_q   <= (parity == 2'd3) ? NO_PARITY : parity_t'(parity);
            stop2_q <= stop_bits;
         end
         if (do_push)
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         if (ovf_set)
            ovf_q <= 1'b1;
         else if (overflow_clr)
            ovf_q <= 1'b0;
      end
   end

   assign valid_o      = !empty;
   assign data_o       = valid_o ? mem_q[rd_ptr_q[AW-1:0]][DATA_MAX-1:0] : '0;
   assign frame_err_o  = valid_o & mem_q[rd_ptr_q[AW-1:0]][DATA_MAX];
   assign parity_err_o = valid_o & mem_q[rd_ptr_q[AW-1:0]][DATA_MAX+1];
   assign overflow_o   = ovf_q;
   assign state_o      = state_q;
   assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames, false start, break, overflow,
// resets and randomized frames checked against a frame-level reference model.
module tb_uart_rx_fifo;

   localparam int DATA_MAX = 9;
   localparam int SW       = 16;
   localparam int DEPTH    = 4;
   localparam int W        = DATA_MAX + 2;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                enable;
   logic [3:0]          data_width;
   logic [1:0]          parity;
   logic                stop_bits;
   logic [SW-1:0]       samples_per_bit;
   logic                rx_in;
   logic [DATA_MAX-1:0] data_o;
   logic                parity_err_o;
   logic                frame_err_o;
   logic                valid_o;
   logic                ready_i;
   logic                overflow_o;
   logic                overflow_clr;
   logic [2:0]          state_o;
   logic                busy_o;

   int                  checks = 0;
   int                  errors = 0;
   logic [W-1:0]        exp_q[$];
   logic                exp_ovf = 1'b0;
   int                  valid_cnt = 0;
   int                  spb = 16;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DATA_MAX(DATA_MAX), .SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .enable          (enable),
      .data_width      (data_width),
      .parity          (parity),
      .stop_bits       (stop_bits),
      .samples_per_bit (samples_per_bit),
      .rx_in           (rx_in),
      .data_o          (data_o),
      .parity_err_o    (parity_err_o),
      .frame_err_o     (frame_err_o),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .overflow_o      (overflow_o),
      .overflow_clr    (overflow_clr),
      .state_o         (state_o),
      .busy_o          (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every accepted head entry is compared with the oldest expected frame.
   always @(negedge clk) begin
      if (valid_o === 1'b1)
         valid_cnt++;
      if (reset_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pop observed=%0h expected=none", {parity_err_o, frame_err_o, data_o});
         end
         if (exp_q.size() != 0)
            chk("head", 32'({parity_err_o, frame_err_o, data_o}), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_in = b;
      tick(spb);
   endtask

   task automatic send_frame(input logic [8:0] d, input int dw_in, input int par_in, input bit s2,
                             input bit pbit_err, input bit st1, input bit st2,
                             input bit scramble, input bit no_gap);
      int         dwe;
      int         ones;
      logic [8:0] m;
      bit         has_par, pbit, perr, ferr;
      dwe = (dw_in < 5) ? 5 : ((dw_in > DATA_MAX) ? DATA_MAX : dw_in);
      m = '0;
      for (int i = 0; i < dwe; i++)
         m[i] = d[i];
      ones    = $countones(m);
      has_par = (par_in == 1) || (par_in == 2);
      pbit    = (par_in == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      pbit    = pbit ^ pbit_err;
      perr    = has_par && pbit_err;
      ferr    = !st1 || (s2 && !st2);
      if (exp_q.size() < DEPTH)
         exp_q.push_back({perr, ferr, m});
      else
         exp_ovf = 1'b1;
      data_width      = 4'(dw_in);
      parity          = 2'(par_in);
      stop_bits       = s2;
      samples_per_bit = SW'(spb);
      drive_bit(1'b0);
      if (scramble) begin
         data_width      = 4'($urandom_range(0, 15));
         parity          = 2'($urandom_range(0, 3));
         stop_bits       = 1'($urandom_range(0, 1));
         samples_per_bit = SW'($urandom_range(4, 40));
      end
      for (int i = 0; i < dwe; i++)
         drive_bit(m[i]);
      if (has_par)
         drive_bit(pbit);
      drive_bit(st1);
      if (s2)
         drive_bit(st2);
      if (!no_gap) begin
         drive_bit(1'b1);
         drive_bit(1'b1);
      end
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++)
         tick(1);
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      reset_n         = 1'b0;
      enable          = 1'b1;
      data_width      = 4'd8;
      parity          = 2'd0;
      stop_bits       = 1'b0;
      samples_per_bit = SW'(16);
      rx_in           = 1'b1;
      ready_i         = 1'b1;
      overflow_clr    = 1'b0;
      tick(3);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_data", 32'(data_o), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_ovf", 32'(overflow_o), 32'd0);
      chk("rst_perr", 32'(parity_err_o), 32'd0);
      chk("rst_ferr", 32'(frame_err_o), 32'd0);
      reset_n = 1'b1;
      tick(4);

      // 8N1 0xA5 with ready held high: one-clock valid pulse
      valid_cnt = 0;
      send_frame(9'h0A5, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(5);
      chk("a5_valid_cycles", 32'(valid_cnt), 32'd1);
      chk("a5_drained", 32'(exp_q.size()), 32'd0);

      // 9E1 0x1FF with parity bit 0
      send_frame(9'h1FF, 9, 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_drain("even_par_drain", 20);

      // 8N2 with second stop low, line then held low
      send_frame(9'h03C, 8, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(3 * spb);
      chk("break_busy", 32'(busy_o), 32'd0);
      chk("break_state", 32'(state_o), 32'd0);
      wait_drain("break_drain", 20);
      rx_in = 1'b1;
      tick(2 * spb);
      send_frame(9'h05A, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_drain("after_break_drain", 20);

      // 5-clock low glitch
      valid_cnt = 0;
      rx_in = 1'b0;
      tick(5);
      rx_in = 1'b1;
      chk("glitch_busy", 32'(busy_o), 32'd1);
      tick(2 * spb);
      chk("glitch_idle", 32'(state_o), 32'd0);
      chk("glitch_valid_cycles", 32'(valid_cnt), 32'd0);

      // Overflow: five frames into a four-entry FIFO with the consumer stalled
      ready_i = 1'b0;
      for (int k = 1; k <= 5; k++)
         send_frame(9'(k), 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(2);
      chk("ovf_valid", 32'(valid_o), 32'd1);
      chk("ovf_flag", 32'(overflow_o), 32'(exp_ovf));
      chk("ovf_head", 32'(data_o), 32'h01);
      ready_i = 1'b1;
      wait_drain("ovf_drain", 30);
      tick(1);
      chk("ovf_empty", 32'(valid_o), 32'd0);
      chk("ovf_sticky", 32'(overflow_o), 32'd1);
      overflow_clr = 1'b1;
      tick(1);
      overflow_clr = 1'b0;
      exp_ovf = 1'b0;
      chk("ovf_clr", 32'(overflow_o), 32'(exp_ovf));

      // Reset in the middle of the data bits of 0x55
      data_width = 4'd8;
      parity     = 2'd0;
      stop_bits  = 1'b0;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      rx_in = 1'b0;
      tick(spb / 2);
      chk("mid_busy", 32'(busy_o), 32'd1);
      reset_n = 1'b0;
      #2;
      chk("mid_rst_outputs", 32'({data_o, valid_o, parity_err_o, frame_err_o, overflow_o, state_o, busy_o}), 32'd0);
      rx_in = 1'b1;
      tick(2);
      reset_n = 1'b1;
      tick(2 * spb);
      send_frame(9'h066, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_drain("post_rst_drain", 20);

      // Enable dropped mid-frame
      drive_bit(1'b0);
      drive_bit(1'b1);
      enable = 1'b0;
      tick(2);
      chk("abort_busy", 32'(busy_o), 32'd0);
      rx_in = 1'b1;
      tick(spb);
      enable = 1'b1;
      tick(spb);
      send_frame(9'h0C3, 8, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_drain("abort_drain", 20);

      // Randomized frames with config scrambled after the start bit
      for (int n = 0; n < 24; n++) begin
         spb = $urandom_range(8, 24);
         send_frame(9'($urandom), $urandom_range(0, 15), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                    1'b1, 1'b0);
      end
      wait_drain("rand_drain", 50);
      chk("rand_no_ovf", 32'(overflow_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
